// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, game command encoding and the debounce FSM states.
// key_to_cmd is the single place where scanner codes map to game commands.
package keypad_pkg;

    localparam logic [3:0] KEY_0 = 4'h0;
    localparam logic [3:0] KEY_1 = 4'h1;
    localparam logic [3:0] KEY_2 = 4'h2;
    localparam logic [3:0] KEY_3 = 4'h3;
    localparam logic [3:0] KEY_4 = 4'h4;
    localparam logic [3:0] KEY_5 = 4'h5;
    localparam logic [3:0] KEY_6 = 4'h6;
    localparam logic [3:0] KEY_7 = 4'h7;
    localparam logic [3:0] KEY_8 = 4'h8;
    localparam logic [3:0] KEY_9 = 4'h9;
    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;
    localparam logic [3:0] KEY_E = 4'hE;
    localparam logic [3:0] KEY_F = 4'hF;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_UP    = 3'd1,
        CMD_DOWN  = 3'd2,
        CMD_LEFT  = 3'd3,
        CMD_RIGHT = 3'd4,
        CMD_BOMB  = 3'd5,
        CMD_START = 3'd6
    } cmd_t;

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        IDLE = 2'd1,
        QUAL = 2'd2
    } state_t;

    function automatic cmd_t key_to_cmd(input logic [3:0] key);
        cmd_t c;
        case (key)
            KEY_2:   c = CMD_UP;
            KEY_8:   c = CMD_DOWN;
            KEY_4:   c = CMD_LEFT;
            KEY_6:   c = CMD_RIGHT;
            KEY_5:   c = CMD_BOMB;
            KEY_F:   c = CMD_START;
            default: c = CMD_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/keypad_cmd_if.sv
// Command queue handshake toward game control: valid/ready head plus queue status.
interface keypad_cmd_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    logic                                 cmd_valid;
    logic                                 cmd_ready;
    logic [2:0]                           cmd_code;
    logic [3:0]                           cmd_key;
    logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count;
    logic                                 overflow;

    modport master (
        output cmd_valid, cmd_code, cmd_key, fifo_count, overflow,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_code, cmd_key, fifo_count, overflow,
        output cmd_ready
    );
endinterface

// File: rtl/cmd_fifo.sv
// Generic first-word-fall-through FIFO; head is always visible on o_data while not empty.
// A push when full is accepted only if a pop frees a slot in the same cycle.
module cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_push,
    input  logic [WIDTH-1:0]               i_data,
    input  logic                           i_pop,
    output logic [WIDTH-1:0]               o_data,
    output logic [$clog2(DEPTH+1)-1:0]     o_count,
    output logic                           o_full,
    output logic                           o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/keypad_cmd.sv
// Synchronises and debounces the scanner key level, maps each qualified change to a
// game command and queues it for game control.
module keypad_cmd
    import keypad_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 2000000,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned CNT_W         = 21
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    decode,
    keypad_cmd_if.master  cmd
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [3:0]       r_sync1;
    logic [3:0]       r_syncd;
    state_t           r_state;
    state_t           w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [3:0]       r_cand;
    logic [3:0]       w_cand_nx;
    logic [3:0]       r_stable;
    logic [3:0]       w_stable_nx;
    logic             w_event;
    logic             w_cnt_done;

    logic             r_push;
    logic [6:0]       r_push_data;
    logic             r_overflow;
    logic [6:0]       w_fifo_data;
    logic             w_full;
    logic             w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_syncd  <= '0;
            r_state  <= ARM;
            r_cnt    <= '0;
            r_cand   <= '0;
            r_stable <= '0;
        end else begin
            r_sync1  <= decode;
            r_syncd  <= r_sync1;
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_cand   <= w_cand_nx;
            r_stable <= w_stable_nx;
        end
    end

    assign w_cnt_done = (r_cnt == CNT_LAST);

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_cand_nx   = r_cand;
        w_stable_nx = r_stable;
        w_event     = 1'b0;
        case (r_state)
            ARM: begin
                if (r_syncd != r_cand) begin
                    w_cand_nx = r_syncd;
                    w_cnt_nx  = '0;
                end else if (w_cnt_done) begin
                    w_stable_nx = r_cand;
                    w_state_nx  = IDLE;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            IDLE: begin
                if (r_syncd != r_stable) begin
                    w_cand_nx  = r_syncd;
                    w_cnt_nx   = '0;
                    w_state_nx = QUAL;
                end
            end
            QUAL: begin
                // Returning to the accepted value wins over any in-flight candidate.
                if (r_syncd == r_stable) begin
                    w_state_nx = IDLE;
                end else if (r_syncd != r_cand) begin
                    w_cand_nx = r_syncd;
                    w_cnt_nx  = '0;
                end else if (w_cnt_done) begin
                    w_stable_nx = r_cand;
                    w_event     = 1'b1;
                    w_state_nx  = IDLE;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nx = ARM;
        endcase
    end

    // Event is registered, so the push lands one cycle after qualification.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_push      <= w_event && (key_to_cmd(r_cand) != CMD_NONE);
            r_push_data <= {key_to_cmd(r_cand), r_cand};
            if (r_push && w_full && !cmd.cmd_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    cmd_fifo #(
        .WIDTH (7),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_push),
        .i_data  (r_push_data),
        .i_pop   (cmd.cmd_ready),
        .o_data  (w_fifo_data),
        .o_count (cmd.fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign cmd.cmd_valid = !w_empty;
    assign cmd.cmd_code  = w_fifo_data[6:4];
    assign cmd.cmd_key   = w_fifo_data[3:0];
    assign cmd.overflow  = r_overflow;

endmodule

// File: tb/tb_keypad_cmd.sv
// Directed bench for keypad_cmd with a short debounce window and a 4-entry queue.
module tb_keypad_cmd;
    import keypad_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] decode;
    int         checks;
    int         failures;

    keypad_cmd_if #(.FIFO_DEPTH(4)) kif ();

    keypad_cmd #(
        .STABLE_CYCLES (8),
        .FIFO_DEPTH    (4),
        .CNT_W         (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .decode (decode),
        .cmd    (kif.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        decode = 4'h1;
        kif.cmd_ready = 1'b0;
        step(3);
        checks++; if (kif.cmd_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", kif.cmd_valid); end
        checks++; if (kif.fifo_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", kif.fifo_count); end
        checks++; if (kif.overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow got=%0b exp=0", kif.overflow); end
        checks++; if (dut.r_state !== ARM) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", dut.r_state, ARM); end
        rst_n = 1'b1;
        step(20);
        checks++; if (kif.cmd_valid !== 1'b0) begin failures++; $display("FAIL base_valid got=%0b exp=0", kif.cmd_valid); end
        checks++; if (kif.fifo_count !== 3'd0) begin failures++; $display("FAIL base_count got=%0d exp=0", kif.fifo_count); end
        checks++; if (dut.r_state !== IDLE) begin failures++; $display("FAIL base_state got=%0d exp=%0d", dut.r_state, IDLE); end
        checks++; if (dut.r_stable !== 4'h1) begin failures++; $display("FAIL base_stable got=%0h exp=1", dut.r_stable); end
    endtask

    task automatic test_clean_press();
        decode = 4'h2;
        step(11);
        checks++; if (kif.cmd_valid !== 1'b0) begin failures++; $display("FAIL press_early got=%0b exp=0", kif.cmd_valid); end
        step(1);
        checks++; if (kif.cmd_valid !== 1'b1) begin failures++; $display("FAIL press_valid got=%0b exp=1", kif.cmd_valid); end
        checks++; if (kif.cmd_code !== 3'd1) begin failures++; $display("FAIL press_code got=%0d exp=1", kif.cmd_code); end
        checks++; if (kif.cmd_key !== 4'h2) begin failures++; $display("FAIL press_key got=%0h exp=2", kif.cmd_key); end
        kif.cmd_ready = 1'b1;
        step(1);
        kif.cmd_ready = 1'b0;
        checks++; if (kif.cmd_valid !== 1'b0) begin failures++; $display("FAIL press_pop_valid got=%0b exp=0", kif.cmd_valid); end
        checks++; if (kif.fifo_count !== 3'd0) begin failures++; $display("FAIL press_pop_count got=%0d exp=0", kif.fifo_count); end
    endtask

    task automatic test_bounce();
        decode = 4'h1;
        step(15);
        checks++; if (kif.fifo_count !== 3'd0) begin failures++; $display("FAIL bounce_pre_count got=%0d exp=0", kif.fifo_count); end
        checks++; if (dut.r_stable !== 4'h1) begin failures++; $display("FAIL bounce_pre_stable got=%0h exp=1", dut.r_stable); end
        decode = 4'h8; step(5);
        decode = 4'h1; step(4);
        decode = 4'h8; step(3);
        decode = 4'h1; step(20);
        checks++; if (kif.cmd_valid !== 1'b0) begin failures++; $display("FAIL bounce_valid got=%0b exp=0", kif.cmd_valid); end
        checks++; if (kif.fifo_count !== 3'd0) begin failures++; $display("FAIL bounce_count got=%0d exp=0", kif.fifo_count); end
        checks++; if (dut.r_stable !== 4'h1) begin failures++; $display("FAIL bounce_stable got=%0h exp=1", dut.r_stable); end
    endtask

    task automatic test_unmapped();
        decode = 4'hA;
        step(15);
        checks++; if (kif.fifo_count !== 3'd0) begin failures++; $display("FAIL unmap_count got=%0d exp=0", kif.fifo_count); end
        checks++; if (dut.r_stable !== 4'hA) begin failures++; $display("FAIL unmap_stable got=%0h exp=A", dut.r_stable); end
        decode = 4'h6;
        step(15);
        checks++; if (kif.fifo_count !== 3'd1) begin failures++; $display("FAIL unmap_right_count got=%0d exp=1", kif.fifo_count); end
        checks++; if (kif.cmd_code !== 3'd4) begin failures++; $display("FAIL unmap_right_code got=%0d exp=4", kif.cmd_code); end
        checks++; if (kif.cmd_key !== 4'h6) begin failures++; $display("FAIL unmap_right_key got=%0h exp=6", kif.cmd_key); end
        kif.cmd_ready = 1'b1;
        step(1);
        kif.cmd_ready = 1'b0;
        checks++; if (kif.fifo_count !== 3'd0) begin failures++; $display("FAIL unmap_pop_count got=%0d exp=0", kif.fifo_count); end
    endtask

    task automatic test_overflow();
        logic [3:0] keys  [5];
        logic [2:0] codes [4];
        keys  = '{4'h2, 4'h8, 4'h4, 4'h6, 4'h5};
        codes = '{3'd1, 3'd2, 3'd3, 3'd4};
        kif.cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            decode = keys[i];
            step(14);
        end
        checks++; if (kif.fifo_count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", kif.fifo_count); end
        checks++; if (kif.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", kif.overflow); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (kif.cmd_valid !== 1'b1) begin failures++; $display("FAIL drain_valid[%0d] got=%0b exp=1", i, kif.cmd_valid); end
            checks++; if (kif.cmd_code !== codes[i]) begin failures++; $display("FAIL drain_code[%0d] got=%0d exp=%0d", i, kif.cmd_code, codes[i]); end
            checks++; if (kif.cmd_key !== keys[i]) begin failures++; $display("FAIL drain_key[%0d] got=%0h exp=%0h", i, kif.cmd_key, keys[i]); end
            kif.cmd_ready = 1'b1;
            step(1);
            kif.cmd_ready = 1'b0;
        end
        checks++; if (kif.cmd_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0b exp=0", kif.cmd_valid); end
        checks++; if (kif.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", kif.overflow); end
    endtask

    task automatic test_full_pushpop_reset();
        logic [3:0] keys [4];
        keys = '{4'h2, 4'h8, 4'h4, 4'h6};
        rst_n = 1'b0;
        decode = 4'h5;
        step(2);
        rst_n = 1'b1;
        step(20);
        for (int i = 0; i < 4; i++) begin
            decode = keys[i];
            step(14);
        end
        checks++; if (kif.fifo_count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", kif.fifo_count); end
        checks++; if (kif.overflow !== 1'b0) begin failures++; $display("FAIL full_no_ovf got=%0b exp=0", kif.overflow); end
        decode = 4'hF;
        step(11);
        kif.cmd_ready = 1'b1;
        step(1);
        kif.cmd_ready = 1'b0;
        checks++; if (kif.fifo_count !== 3'd4) begin failures++; $display("FAIL pushpop_count got=%0d exp=4", kif.fifo_count); end
        checks++; if (kif.overflow !== 1'b0) begin failures++; $display("FAIL pushpop_ovf got=%0b exp=0", kif.overflow); end
        checks++; if (kif.cmd_code !== 3'd2) begin failures++; $display("FAIL pushpop_head got=%0d exp=2", kif.cmd_code); end
        checks++; if (kif.cmd_key !== 4'h8) begin failures++; $display("FAIL pushpop_key got=%0h exp=8", kif.cmd_key); end
        decode = 4'h5;
        step(14);
        checks++; if (kif.overflow !== 1'b1) begin failures++; $display("FAIL drop_ovf got=%0b exp=1", kif.overflow); end
        decode = 4'h2;
        step(6);
        checks++; if (dut.r_state !== QUAL) begin failures++; $display("FAIL midqual_state got=%0d exp=%0d", dut.r_state, QUAL); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (kif.cmd_valid !== 1'b0) begin failures++; $display("FAIL async_valid got=%0b exp=0", kif.cmd_valid); end
        checks++; if (kif.fifo_count !== 3'd0) begin failures++; $display("FAIL async_count got=%0d exp=0", kif.fifo_count); end
        checks++; if (kif.overflow !== 1'b0) begin failures++; $display("FAIL async_ovf got=%0b exp=0", kif.overflow); end
        checks++; if (dut.r_state !== ARM) begin failures++; $display("FAIL async_state got=%0d exp=%0d", dut.r_state, ARM); end
        #1;
        rst_n = 1'b1;
        step(25);
        checks++; if (kif.fifo_count !== 3'd0) begin failures++; $display("FAIL post_rst_count got=%0d exp=0", kif.fifo_count); end
        checks++; if (dut.r_state !== IDLE) begin failures++; $display("FAIL post_rst_state got=%0d exp=%0d", dut.r_state, IDLE); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        decode   = 4'h0;
        kif.cmd_ready = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_unmapped();
        test_overflow();
        test_full_pushpop_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
